// File: rtl/uart8_receiver.sv
// uart8_receiver: 8N1 UART receiver with oversampled start/data/stop sampling.
//   clk   - sole clock, OVERSAMPLE x baud rate
//   rst_n - asynchronous active-low reset
//   en    - receiver enable; low aborts any frame and returns to IDLE
//   in    - serial line (asynchronous, idles high, LSB first)
//   out   - last received byte, held until the next done
//   done  - one-cycle pulse when a frame completes
//   busy  - high while a frame is being received
//   err   - framing error (stop bit low), updated with done
module uart8_receiver #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       in,
   output logic [7:0] out,
   output logic       done,
   output logic       busy,
   output logic       err
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] half = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] last = CW'(OVERSAMPLE - 1);
   typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT, RECOVER} state_t;
   state_t        state;
   logic [1:0]    sync;
   logic          in_sync;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shift;
   assign in_sync = sync[1];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync <= 2'b11;
      else sync <= {sync[0], in};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
         out   <= '0;
         done  <= 1'b0;
         busy  <= 1'b0;
         err   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: if (!in_sync) begin
                  state <= START_BIT;
                  busy  <= 1'b1;
                  cnt   <= '0;
               end
               // mid-bit recheck of the start bit rejects short low glitches
               START_BIT: if (cnt == half) begin
                  cnt   <= '0;
                  idx   <= '0;
                  state <= in_sync ? IDLE : DATA_BITS;
                  busy  <= ~in_sync;
               end else cnt <= cnt + CW'(1);
               DATA_BITS: if (cnt == last) begin
                  shift[idx] <= in_sync;
                  cnt        <= '0;
                  idx        <= idx + 3'd1;
                  if (idx == 3'd7) state <= STOP_BIT;
               end else cnt <= cnt + CW'(1);
               STOP_BIT: if (cnt == last) begin
                  out   <= shift;
                  done  <= 1'b1;
                  err   <= ~in_sync;
                  busy  <= 1'b0;
                  cnt   <= '0;
                  state <= in_sync ? IDLE : RECOVER;
               end else cnt <= cnt + CW'(1);
               // a held-low line (break) must go high before a new start is accepted
               RECOVER: if (in_sync) state <= IDLE;
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: doc/uart8_receiver.md
UART8_RECEIVER -- requirements
Module: uart8_receiver

Interface
REQ-001 Parameter OVERSAMPLE, default 16: clk cycles per bit; even; at least 4.
REQ-002 Port clk, input, 1: sole clock, rising edge; frequency is OVERSAMPLE x baud rate.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port en, input, 1: receiver enable; low forces IDLE and aborts any frame in progress.
REQ-005 Port in, input, 1: serial line; asynchronous to clk; idles high; frame is 8N1, LSB first.
REQ-006 Port out, output, 8: last received byte; held until the next done pulse.
REQ-007 Port done, output, 1: single-cycle pulse when a frame completes.
REQ-008 Port busy, output, 1: high while a frame is being received.
REQ-009 Port err, output, 1: framing error flag; valid in the done cycle; held until the next done.

Function
REQ-010 in SHALL pass through a 2-flop synchronizer whose output is in_sync; all decisions use in_sync only.
REQ-011 States SHALL be IDLE, START_BIT, DATA_BITS, STOP_BIT and RECOVER.
REQ-012 IDLE: in_sync=0 with en=1 SHALL go to START_BIT with the sample counter cleared to 0.
REQ-013 START_BIT: the counter increments each cycle; at counter=OVERSAMPLE/2-1:
- in_sync=0 SHALL go to DATA_BITS, counter 0, bit index 0.
- otherwise (glitch) SHALL go to IDLE with no done pulse.
REQ-014 DATA_BITS: at counter=OVERSAMPLE-1:
- SHALL shift in_sync into bit [index] of the shift register and clear the counter.
- after index 7 SHALL go to STOP_BIT.
REQ-015 STOP_BIT: at counter=OVERSAMPLE-1:
- SHALL load out from the shift register, pulse done for exactly 1 cycle, and set err=~in_sync.
- in_sync=1 SHALL go to IDLE; in_sync=0 SHALL go to RECOVER.
REQ-016 RECOVER SHALL wait for in_sync=1, then go to IDLE; a low line (break) is never taken as a new start bit.
REQ-017 busy SHALL be 1 exactly in START_BIT, DATA_BITS and STOP_BIT, and 0 in IDLE and RECOVER.
REQ-018 Latency: with OVERSAMPLE=16, done SHALL assert on the 155th rising edge counting the edge that first samples in=0 as edge 1.
- Derivation: 2 synchronizer + 1 detect + 8 start + 128 data + 16 stop.
REQ-019 A new falling edge SHALL be accepted on the cycle IDLE is re-entered, so back-to-back frames need no gap beyond the stop bit.
REQ-020 en low in any state SHALL go to IDLE on the next edge; out and err hold, done stays 0, busy drops.
REQ-021 done and the state transition are evaluated in the same cycle; err and out update only with done.

Reset
REQ-022 rst_n low SHALL asynchronously set: state IDLE, counter 0, index 0, shift register 0, both synchronizer flops 1, out 8'h00, done 0, busy 0, err 0.
REQ-023 Reset asserted mid-frame SHALL discard the frame; after release, reception resumes on the next falling edge of in_sync.

Verification
REQ-024 Frame 0x55, OVERSAMPLE=16, 16-clk bits -> done on edge 155, out=8'h55, err=0, busy high 152 cycles.
REQ-025 Back-to-back 0x55 then 0x96 with no idle gap -> two done pulses 160 cycles apart; out=8'h55, then 8'h96; err=0 both times.
REQ-026 Low glitch of 4 clk in IDLE -> no done; busy pulses high, then state returns to IDLE; out unchanged.
REQ-027 Frame 0xA3 with stop bit driven low, line held low 40 clk, then high -> done with out=8'hA3 and err=1; busy=0 in RECOVER; no spurious frame.
REQ-028 en deasserted at data bit 3 of frame 0x0F -> busy=0 on the next edge, no done; the next clean frame 0xF0 gives out=8'hF0.
REQ-029 rst_n pulsed low mid-frame -> all outputs are 0 immediately (asynchronously); the following frame 0x3C is received correctly.
